// File: rtl/spi_ctrl.sv
// SPI master, mode 0, MSB first, with a small memory-mapped register block.
// One 8-bit transfer per TXDATA write; chip select is software controlled.
module spi_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic [31:0] rdata,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10
  } state_e;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_TXDATA = 8'h08;
  localparam logic [7:0] A_RXDATA = 8'h0C;

  state_e     state_q, state_d;
  logic       en_q, en_d;
  logic [6:0] div_q, div_d;
  logic       csf_q, csf_d;
  logic [6:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       mosi_q, mosi_d;
  logic [7:0] rx_q, rx_d;
  logic       rxv_q, rxv_d;

  logic [7:0] addr;
  logic       wr, rd, busy, tx_go, rx_rd, ph_end;
  logic       unused_ok;

  assign addr   = req_addr[7:0];
  assign wr     = req_valid && req_write;
  assign rd     = req_valid && !req_write;
  assign busy   = (state_q != ST_IDLE);
  assign tx_go  = wr && (addr == A_TXDATA) && req_wstrb[0]
                  && en_q && !busy;
  assign rx_rd  = rd && (addr == A_RXDATA);
  // Compared with >= so a shrinking clk_div cannot strand the counter.
  assign ph_end = (cnt_q >= div_q);

  assign unused_ok = ^{req_addr[31:8], req_wdata[31:9],
                       req_wstrb[3:2]};

  assign spi_cs_n = !(en_q && csf_q);
  assign spi_sck  = (state_q == ST_HIGH);
  assign spi_mosi = mosi_q;

  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      unique case (addr)
        A_CTRL:   rdata = {23'h0, csf_q, div_q, en_q};
        A_STATUS: rdata = {30'h0, rxv_q, busy};
        A_RXDATA: rdata = {24'h0, rx_q};
        default:  rdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    div_d   = div_q;
    csf_d   = csf_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    mosi_d  = mosi_q;
    rx_d    = rx_q;
    rxv_d   = rxv_q;

    if (wr && addr == A_CTRL) begin
      if (req_wstrb[0]) {div_d, en_d} = req_wdata[7:0];
      if (req_wstrb[1]) csf_d = req_wdata[8];
    end

    if (rx_rd) rxv_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_go) begin
          sh_d    = req_wdata[7:0];
          mosi_d  = req_wdata[7];
          cnt_d   = 7'd0;
          bit_d   = 3'd0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (ph_end) begin
          cnt_d   = 7'd0;
          sh_d    = {sh_q[6:0], spi_miso};
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_HIGH: begin
        if (ph_end) begin
          cnt_d = 7'd0;
          if (bit_q == 3'd7) begin
            state_d = ST_IDLE;
            rx_d    = sh_q;
            rxv_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            mosi_d  = sh_q[7];
            state_d = ST_LOW;
          end
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabling mid-transfer abandons the byte without completing it.
    if (!en_d && busy) begin
      state_d = ST_IDLE;
      cnt_d   = 7'd0;
      rx_d    = rx_q;
      rxv_d   = rxv_q && !rx_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      div_q   <= 7'd0;
      csf_q   <= 1'b0;
      cnt_q   <= 7'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      mosi_q  <= 1'b0;
      rx_q    <= 8'd0;
      rxv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      div_q   <= div_d;
      csf_q   <= csf_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      mosi_q  <= mosi_d;
      rx_q    <= rx_d;
      rxv_q   <= rxv_d;
    end
  end

endmodule

// File: tb/tb_spi_ctrl.sv
// Self-checking bench for spi_ctrl with a behavioural SPI slave
// (JEDEC-ID / read-command flash or random responder).
module tb_spi_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wstrb = 4'h0;
  logic [31:0] rdata;
  logic        spi_cs_n, spi_sck, spi_mosi;
  logic        spi_miso = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rises[$];
  logic [7:0] last_rx = 8'h0;

  spi_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .rdata(rdata),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge spi_sck) rises.push_back(cyc);

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  // ---------------- slave model ----------------
  logic [7:0] rq[$];
  logic [7:0] sentq[$];
  logic [7:0] rsh = 8'h0;
  logic [7:0] resp = 8'h0;
  int rcnt = 0;
  bit rmode = 1'b0;
  bit mreq = 1'b0;
  bit mack = 1'b0;

  function automatic logic [7:0] flash_resp(int k);
    logic [23:0] ad;
    flash_resp = 8'h00;
    if (rq.size() >= 1 && rq[0] == 8'h9F) begin
      case (k)
        1: flash_resp = 8'hEF;
        2: flash_resp = 8'h40;
        3: flash_resp = 8'h16;
        default: flash_resp = 8'h00;
      endcase
    end else if (rq.size() >= 4 && rq[0] == 8'h03 && k >= 4) begin
      ad = {rq[1], rq[2], rq[3]};
      flash_resp = 8'(ad + 24'(k - 4));
    end
  endfunction

  function automatic void next_resp();
    if (rmode) begin
      resp = 8'($urandom_range(0, 255));
      sentq.push_back(resp);
    end else begin
      resp = flash_resp(rq.size());
    end
  endfunction

  always @(spi_sck or mreq) begin
    if (mreq != mack) begin
      mack = mreq;
      rq.delete();
      sentq.delete();
      rcnt = 0;
      next_resp();
      spi_miso = resp[7];
    end else if (spi_sck) begin
      rsh = {rsh[6:0], spi_mosi};
      rcnt++;
      if (rcnt == 8) begin
        rq.push_back(rsh);
        rcnt = 0;
        next_resp();
      end
    end else begin
      spi_miso = resp[3'(7 - rcnt)];
    end
  end

  task automatic model_reset(input bit m);
    rmode = m;
    mreq = ~mreq;
    #1;
  endtask

  // ---------------- bus tasks ----------------
  task automatic bwr(input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = {24'h0, a};
    req_wdata = d;
    req_wstrb = s;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wstrb = 4'h0;
  endtask

  task automatic brd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = {24'h0, a};
    #1 d = rdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h4;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      #1;
      if (rdata[0]) n++;
      else done = 1'b1;
    end
    req_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_done: busy still %0d after %0d cycles",
               rdata[0], n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({spi_cs_n, spi_sck, spi_mosi} !== 3'b100) begin
      errors++;
      $display("FAIL reset_pins: got cs/sck/mosi=%b want 100",
               {spi_cs_n, spi_sck, spi_mosi});
    end
    @(negedge clk) rst = 1'b0;
    brd(8'h00, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h want 0", d);
    end
    brd(8'h04, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_status: got %h want 0", d);
    end
    brd(8'h0C, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_rxdata: got %h want 0", d);
    end
  endtask

  task automatic test_ctrl();
    logic [31:0] d;
    bwr(8'h00, 32'hFFFF_FFFF, 4'b0001);
    brd(8'h00, d);
    checks++;
    if (d !== 32'h0000_00FF || spi_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_lane0: got %h cs_n=%b want 000000ff cs_n=1",
               d, spi_cs_n);
    end
    bwr(8'h00, 32'h0000_0100, 4'b0010);
    brd(8'h00, d);
    checks++;
    if (d !== 32'h0000_01FF || spi_cs_n !== 1'b0) begin
      errors++;
      $display("FAIL ctrl_lane1: got %h cs_n=%b want 000001ff cs_n=0",
               d, spi_cs_n);
    end
    bwr(8'h00, 32'h0000_0005, 4'hF);
    brd(8'h00, d);
    checks++;
    if (d !== 32'h0000_0005 || spi_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_5: got %h cs_n=%b want 00000005 cs_n=1",
               d, spi_cs_n);
    end
    brd(8'h30, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_read: got %h want 0", d);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL idle_rdata: got %h want 0", rdata);
    end
  endtask

  task automatic test_jedec();
    logic [31:0] d;
    logic [7:0] exp_b[4];
    int n;
    exp_b = '{8'h00, 8'hEF, 8'h40, 8'h16};
    model_reset(1'b0);
    bwr(8'h00, 32'h0000_0105, 4'b0011);
    checks++;
    if (spi_cs_n !== 1'b0) begin
      errors++;
      $display("FAIL jedec_cs: got %b want 0", spi_cs_n);
    end
    for (int i = 0; i < 4; i++) begin
      bwr(8'h08, (i == 0) ? 32'h9F : 32'h00, 4'b0001);
      brd(8'h04, d);
      checks++;
      if (d[0] !== 1'b1) begin
        errors++;
        $display("FAIL jedec_busy%0d: got %b want 1", i, d[0]);
      end
      wait_done(n);
      brd(8'h0C, d);
      if (i > 0) begin
        checks++;
        if (d !== {24'h0, exp_b[i]}) begin
          errors++;
          $display("FAIL jedec_rx%0d: got %h want %h", i, d, exp_b[i]);
        end
      end
    end
    checks++;
    if (rq.size() != 4 || rq[0] !== 8'h9F) begin
      errors++;
      $display("FAIL jedec_mosi: got %0d bytes want 4 starting 9f",
               rq.size());
    end
    bwr(8'h00, 32'h0000_0005, 4'b0011);
    checks++;
    if (spi_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL jedec_cs_rel: got %b want 1", spi_cs_n);
    end
  endtask

  task automatic test_read_cmd();
    logic [31:0] d;
    logic [7:0] tx[8];
    int n;
    tx = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    model_reset(1'b0);
    bwr(8'h00, 32'h0000_0105, 4'b0011);
    for (int i = 0; i < 8; i++) begin
      bwr(8'h08, {24'h0, tx[i]}, 4'b0001);
      wait_done(n);
      brd(8'h04, d);
      checks++;
      if (d !== 32'h2) begin
        errors++;
        $display("FAIL read_status%0d: got %h want 2", i, d);
      end
      brd(8'h0C, d);
      if (i >= 4) begin
        checks++;
        if (d !== 32'(8'h10 + i - 4)) begin
          errors++;
          $display("FAIL read_data%0d: got %h want %h", i, d,
                   8'h10 + i - 4);
        end
      end
      brd(8'h04, d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL read_status_clr%0d: got %h want 0", i, d);
      end
    end
    bwr(8'h00, 32'h0000_0005, 4'b0011);
  endtask

  task automatic test_timing();
    logic [31:0] d;
    logic [7:0] tx, tx2;
    int n;
    model_reset(1'b1);
    bwr(8'h00, 32'h0000_0105, 4'b0011);
    tx = 8'($urandom_range(0, 255));
    rises.delete();
    bwr(8'h08, {24'h0, tx}, 4'b0001);
    wait_done(n);
    checks++;
    if (n != 48) begin
      errors++;
      $display("FAIL busy_len: got %0d want 48", n);
    end
    checks++;
    if (rises.size() != 8 || rises[1] - rises[0] != 6) begin
      errors++;
      $display("FAIL sck_period: got %0d rises, period %0d want 8, 6",
               rises.size(),
               (rises.size() > 1) ? rises[1] - rises[0] : -1);
    end
    brd(8'h0C, d);
    checks++;
    if (d !== {24'h0, sentq[0]} || rq[rq.size()-1] !== tx) begin
      errors++;
      $display("FAIL timing_data: rx %h want %h, mosi %h want %h",
               d, sentq[0], rq[rq.size()-1], tx);
    end
    tx2 = 8'($urandom_range(0, 255));
    bwr(8'h08, {24'h0, tx2}, 4'b0001);
    bwr(8'h08, {24'h0, ~tx2}, 4'b0001);
    wait_done(n);
    brd(8'h0C, d);
    checks++;
    if (d !== {24'h0, sentq[1]} || rq[rq.size()-1] !== tx2
        || rq.size() != 2) begin
      errors++;
      $display("FAIL busy_write: rx %h want %h, mosi %h want %h",
               d, sentq[1], rq[rq.size()-1], tx2);
    end
    last_rx = sentq[1];
    bwr(8'h00, 32'h0000_0104, 4'b0011);
    bwr(8'h08, 32'h0000_00AA, 4'b0001);
    brd(8'h04, d);
    checks++;
    if (d !== 32'h0 || spi_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL tx_disabled: status %h cs_n %b want 0, 1",
               d, spi_cs_n);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [7:0] tx;
    int dv, n;
    model_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      dv = $urandom_range(0, 3);
      bwr(8'h00, 32'h100 | 32'(dv << 1) | 32'h1, 4'b0011);
      tx = 8'($urandom_range(0, 255));
      bwr(8'h08, {24'h0, tx}, 4'b0001);
      wait_done(n);
      checks++;
      if (n != 16 * (dv + 1)) begin
        errors++;
        $display("FAIL rand_len%0d: got %0d want %0d", k, n,
                 16 * (dv + 1));
      end
      brd(8'h04, d);
      checks++;
      if (d !== 32'h2) begin
        errors++;
        $display("FAIL rand_status%0d: got %h want 2", k, d);
      end
      brd(8'h0C, d);
      checks++;
      if (d !== {24'h0, sentq[k]} || rq[k] !== tx) begin
        errors++;
        $display("FAIL rand_data%0d: rx %h want %h, mosi %h want %h",
                 k, d, sentq[k], rq[k], tx);
      end
      last_rx = sentq[k];
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    model_reset(1'b1);
    bwr(8'h00, 32'h0000_0107, 4'b0011);
    bwr(8'h08, 32'h0000_005A, 4'b0001);
    repeat (10) @(posedge clk);
    bwr(8'h00, 32'h0000_0106, 4'b0011);
    checks++;
    if (spi_sck !== 1'b0) begin
      errors++;
      $display("FAIL abort_sck: got %b want 0", spi_sck);
    end
    brd(8'h04, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL abort_status: got %h want 0", d);
    end
    brd(8'h0C, d);
    checks++;
    if (d !== {24'h0, last_rx}) begin
      errors++;
      $display("FAIL abort_rxdata: got %h want %h", d, last_rx);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    model_reset(1'b1);
    bwr(8'h00, 32'h0000_0105, 4'b0011);
    bwr(8'h08, 32'h0000_00FF, 4'b0001);
    repeat (7) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({spi_cs_n, spi_sck, spi_mosi} !== 3'b100) begin
      errors++;
      $display("FAIL rst_mid_pins: got cs/sck/mosi=%b want 100",
               {spi_cs_n, spi_sck, spi_mosi});
    end
    @(negedge clk) rst = 1'b0;
    brd(8'h04, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_status: got %h want 0", d);
    end
    brd(8'h00, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_ctrl: got %h want 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_jedec();
    test_read_cmd();
    test_timing();
    test_random();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ctrl.md
SPI_CTRL -- requirements
Module: spi_ctrl

Interface
REQ-001 The block SHALL expose: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 The block SHALL expose: rst  input  1  reset, synchronous and active-high.
REQ-003 The block SHALL expose: req_valid  input  1  bus request strobe, one cycle per access.
REQ-004 The block SHALL expose: req_write  input  1  1 = write, 0 = read.
REQ-005 The block SHALL expose: req_addr  input  32  byte address; only bits [7:0] decoded.
REQ-006 The block SHALL expose: req_wdata  input  32  write data.
REQ-007 The block SHALL expose: req_wstrb  input  4  write byte enables.
REQ-008 The block SHALL expose: rdata  output  32  read data.
REQ-009 The block SHALL expose: spi_cs_n  output  1  chip select, active-low.
REQ-010 The block SHALL expose: spi_sck  output  1  serial clock, mode 0 (idle low).
REQ-011 The block SHALL expose: spi_mosi  output  1  serial data out, MSB first.
REQ-012 The block SHALL expose: spi_miso  input  1  serial data in.

Function
REQ-013 Register map SHALL be: 0x00 CTRL, 0x04 STATUS, 0x08 TXDATA, 0x0C RXDATA; other offsets read 0, writes ignored.
REQ-014 CTRL SHALL hold spi_en [0], clk_div [7:1], cs_force [8]; bits [31:9] read 0; writes apply per byte lane (wstrb[0] -> [7:0], wstrb[1] -> [8]).
REQ-015 STATUS SHALL be read-only: busy [0], rx_valid [1], others 0.
REQ-016 rdata SHALL be combinational: while req_valid && !req_write, it carries the addressed register; otherwise it is 0.
REQ-017 spi_cs_n SHALL equal NOT(spi_en AND cs_force); the block never toggles CS on its own.
REQ-018 A TXDATA write with wstrb[0]=1, spi_en=1 and busy=0 SHALL load req_wdata[7:0] and set busy on the same edge.
REQ-019 A TXDATA write while busy=1 or spi_en=0 SHALL be ignored.
REQ-020 A transfer SHALL be 8 bits, SPI mode 0, MSB first: mosi presents bit 7 from the load edge onward; each bit is sck low for H cycles, then sck high for H cycles; H = clk_div+1 (clk_div=0 gives H=1).
REQ-021 miso SHALL be sampled on the clk edge that raises sck; mosi SHALL change to the next bit on the edge that lowers sck.
REQ-022 A full transfer SHALL take 16*H cycles; on the edge ending the 8th high phase, sck returns low, busy clears, RXDATA[7:0] loads the received byte and rx_valid sets.
REQ-023 A read of RXDATA SHALL return {24'h0, rx byte} and clear rx_valid on that edge; if completion occurs on the same edge, rx_valid SHALL end set.
REQ-024 A new completion while rx_valid=1 SHALL overwrite RXDATA (no overflow flag).
REQ-025 Clearing spi_en during a transfer SHALL abort it on the write edge: busy=0, sck=0, RXDATA and rx_valid unchanged.
REQ-026 A clk_div change during a transfer SHALL take effect at the next phase boundary.
REQ-027 mosi SHALL hold its last driven value when idle.

Reset
REQ-028 With rst=1 at a clk edge, CTRL, RXDATA, shift register and phase counter SHALL clear and busy=0, rx_valid=0, spi_sck=0, spi_mosi=0, spi_cs_n=1; rst mid-transfer aborts with no completion.

Verification
REQ-029 CTRL write 0x0000_0005, read -> 0x0000_0005; spi_cs_n=1.
REQ-030 CTRL=0x105 (cs low); TXDATA 0x9F, then three TXDATA 0x00 against a JEDEC-ID flash model -> received bytes 0xEF, 0x40, 0x16; busy seen =1 after each write; CTRL=0x005 -> spi_cs_n=1.
REQ-031 CS low; send 0x03, 0x00, 0x00, 0x10, then four 0x00 against a flash model whose byte n = n -> data 0x10, 0x11, 0x12, 0x13.
REQ-032 After completion, STATUS=0x2; read RXDATA; next STATUS read = 0x0.
REQ-033 clk_div=2: sck period 6 cycles, busy high exactly 48 cycles; TXDATA write while busy -> no effect on the transfer; TXDATA write with spi_en=0 -> busy stays 0.
REQ-034 Assert rst mid-transfer -> all outputs at reset values next cycle, STATUS=0.
